// File: rtl/latency_monitor.sv
// Ingress-to-decision latency monitor: stamps start events into an in-order FIFO and
// produces per-message latency plus running last/min/max/sum/count statistics.
module latency_monitor #(
  parameter int unsigned TS_W  = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned SUM_W = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [TS_W-1:0]          cycle_cnt,
  input  logic                     start_evt,
  input  logic                     end_evt,
  input  logic                     clear,
  output logic                     lat_valid,
  output logic [TS_W-1:0]          lat_last,
  output logic [TS_W-1:0]          lat_min,
  output logic [TS_W-1:0]          lat_max,
  output logic [SUM_W-1:0]         lat_sum,
  output logic [CNT_W-1:0]         msg_count,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     overflow_err,
  output logic                     underflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [TS_W-1:0]  stamp_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             fifo_empty;
  logic             fifo_full;
  logic             do_pop;
  logic             do_push;
  logic             bypass;
  logic             sample;
  logic             ovf_evt;
  logic             unf_evt;
  logic [TS_W-1:0]  latency;
  logic [SUM_W:0]   sum_wide;
  logic [SUM_W-1:0] sum_next;
  logic [CNT_W-1:0] count_next;
  logic [TS_W-1:0]  min_next;
  logic [TS_W-1:0]  max_next;
  logic [OCC_W-1:0] occ_next;

  always_comb begin
    fifo_empty = (inflight == '0);
    fifo_full  = (inflight == OCC_W'(DEPTH));

    // Start and end together on an empty FIFO is a zero-latency pass-through.
    bypass  = start_evt && end_evt && fifo_empty;
    do_pop  = end_evt && !fifo_empty;
    do_push = start_evt && !bypass && (!fifo_full || do_pop);
    sample  = do_pop || bypass;
    ovf_evt = start_evt && !end_evt && fifo_full;
    unf_evt = end_evt && !start_evt && fifo_empty;

    // Unsigned modular subtraction keeps the result correct across counter wrap.
    latency = bypass ? '0 : (cycle_cnt - stamp_mem[rd_ptr]);
  end

  always_comb begin
    sum_wide   = {1'b0, lat_sum} + (SUM_W + 1)'(latency);
    sum_next   = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
    count_next = (msg_count == '1) ? msg_count : (msg_count + CNT_W'(1));
    min_next   = (latency < lat_min) ? latency : lat_min;
    max_next   = (latency > lat_max) ? latency : lat_max;
  end

  always_comb begin
    occ_next = inflight;
    unique case ({do_push, do_pop})
      2'b10:   occ_next = inflight + OCC_W'(1);
      2'b01:   occ_next = inflight - OCC_W'(1);
      default: occ_next = inflight;
    endcase
  end

  // Timestamp storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stamp_mem[wr_ptr] <= cycle_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      inflight <= occ_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_valid <= 1'b0;
      lat_last  <= '0;
    end else begin
      lat_valid <= sample;
      if (sample) begin
        lat_last <= latency;
      end
    end
  end

  // A sample coincident with clear is reported but not accumulated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_min   <= '1;
      lat_max   <= '0;
      lat_sum   <= '0;
      msg_count <= '0;
    end else if (clear) begin
      lat_min   <= '1;
      lat_max   <= '0;
      lat_sum   <= '0;
      msg_count <= '0;
    end else if (sample) begin
      lat_min   <= min_next;
      lat_max   <= max_next;
      lat_sum   <= sum_next;
      msg_count <= count_next;
    end
  end

  // An error in the same cycle as clear leaves its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      overflow_err  <= (overflow_err && !clear) || ovf_evt;
      underflow_err <= (underflow_err && !clear) || unf_evt;
    end
  end

endmodule

// File: tb/tb_latency_monitor.sv
// Self-checking bench for latency_monitor: directed vector table, hand sequences for
// full/drain and async reset, and randomized traffic against a queue-based model.
module tb_latency_monitor;

  localparam int unsigned TS_W  = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned SUM_W = 48;
  localparam logic [63:0] ONES32 = 64'h0000_0000_FFFF_FFFF;
  localparam longint unsigned SUM_MAX = 64'h0000_FFFF_FFFF_FFFF;
  localparam longint unsigned CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  logic                   clk;
  logic                   rst_n;
  logic [TS_W-1:0]        cycle_cnt;
  logic                   start_evt;
  logic                   end_evt;
  logic                   clear;
  logic                   lat_valid;
  logic [TS_W-1:0]        lat_last;
  logic [TS_W-1:0]        lat_min;
  logic [TS_W-1:0]        lat_max;
  logic [SUM_W-1:0]       lat_sum;
  logic [CNT_W-1:0]       msg_count;
  logic [$clog2(DEPTH):0] inflight;
  logic                   overflow_err;
  logic                   underflow_err;

  latency_monitor #(
    .TS_W (TS_W),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W),
    .SUM_W(SUM_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cycle_cnt    (cycle_cnt),
    .start_evt    (start_evt),
    .end_evt      (end_evt),
    .clear        (clear),
    .lat_valid    (lat_valid),
    .lat_last     (lat_last),
    .lat_min      (lat_min),
    .lat_max      (lat_max),
    .lat_sum      (lat_sum),
    .msg_count    (msg_count),
    .inflight     (inflight),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0]     m_q[$];
  bit              m_valid;
  logic [31:0]     m_last;
  logic [31:0]     m_min;
  logic [31:0]     m_max;
  longint unsigned m_sum;
  longint unsigned m_cnt;
  bit              m_ovf;
  bit              m_unf;

  typedef struct {
    bit          s;
    bit          e;
    bit          clr;
    logic [31:0] cc;
    bit          ev;
    logic [31:0] el;
    int          ei;
    logic [31:0] emin;
    logic [31:0] emax;
    longint      esum;
    int          ecnt;
    bit          eovf;
    bit          eunf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit s, bit e, bit clr, logic [31:0] cc, bit ev, logic [31:0] el,
                              int ei, logic [31:0] emin, logic [31:0] emax, longint esum,
                              int ecnt, bit eovf, bit eunf);
    vec_t v;
    v.s = s; v.e = e; v.clr = clr; v.cc = cc; v.ev = ev; v.el = el; v.ei = ei;
    v.emin = emin; v.emax = emax; v.esum = esum; v.ecnt = ecnt; v.eovf = eovf; v.eunf = eunf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_valid = 1'b0;
    m_last  = '0;
    m_min   = '1;
    m_max   = '0;
    m_sum   = 0;
    m_cnt   = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit e, input bit clr, input logic [31:0] cc);
    bit          smp = 1'b0;
    bit          ovf = 1'b0;
    bit          unf = 1'b0;
    logic [31:0] lat = '0;
    if (e) begin
      if (m_q.size() > 0) begin
        lat = cc - m_q.pop_front();
        smp = 1'b1;
        if (s) m_q.push_back(cc);
      end else if (s) begin
        smp = 1'b1;
        lat = '0;
      end else begin
        unf = 1'b1;
      end
    end else if (s) begin
      if (m_q.size() < DEPTH) m_q.push_back(cc);
      else ovf = 1'b1;
    end
    m_valid = smp;
    if (smp) m_last = lat;
    if (clr) begin
      m_min = '1; m_max = '0; m_sum = 0; m_cnt = 0;
    end else if (smp) begin
      if (lat < m_min) m_min = lat;
      if (lat > m_max) m_max = lat;
      m_sum = (m_sum + lat > SUM_MAX) ? SUM_MAX : m_sum + lat;
      m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
    end
    m_ovf = (m_ovf && !clr) || ovf;
    m_unf = (m_unf && !clr) || unf;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".valid"}, 64'(lat_valid), 64'(m_valid));
    chk({tag, ".last"}, 64'(lat_last), 64'(m_last));
    chk({tag, ".min"}, 64'(lat_min), 64'(m_min));
    chk({tag, ".max"}, 64'(lat_max), 64'(m_max));
    chk({tag, ".sum"}, 64'(lat_sum), m_sum);
    chk({tag, ".count"}, 64'(msg_count), m_cnt);
    chk({tag, ".inflight"}, 64'(inflight), 64'(m_q.size()));
    chk({tag, ".ovf"}, 64'(overflow_err), 64'(m_ovf));
    chk({tag, ".unf"}, 64'(underflow_err), 64'(m_unf));
  endtask

  // Called at posedge+1; presents inputs for the next edge and checks after it.
  task automatic step(input bit s, input bit e, input bit clr, input logic [31:0] cc,
                      input string tag);
    start_evt = s; end_evt = e; clear = clr; cycle_cnt = cc;
    @(posedge clk);
    #1;
    model_step(s, e, clr, cc);
    compare_model(tag);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".valid"}, 64'(lat_valid), 64'd0);
    chk({tag, ".last"}, 64'(lat_last), 64'd0);
    chk({tag, ".min"}, 64'(lat_min), ONES32);
    chk({tag, ".max"}, 64'(lat_max), 64'd0);
    chk({tag, ".sum"}, 64'(lat_sum), 64'd0);
    chk({tag, ".count"}, 64'(msg_count), 64'd0);
    chk({tag, ".inflight"}, 64'(inflight), 64'd0);
    chk({tag, ".ovf"}, 64'(overflow_err), 64'd0);
    chk({tag, ".unf"}, 64'(underflow_err), 64'd0);
  endtask

  initial begin
    logic [31:0] drain_exp [8];
    logic [31:0] cc_r;
    bit          s_r;
    bit          e_r;
    bit          c_r;
    string       tag;

    rst_n = 1'b0; start_evt = 1'b0; end_evt = 1'b0; clear = 1'b0; cycle_cnt = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset");
    rst_n = 1'b1;

    //            s  e  clr cc            ev last         in min           max  sum cnt ovf unf
    tbl.push_back(mk(1, 0, 0, 10,           0, 0,          1, 32'hFFFF_FFFF, 0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 11,           0, 0,          1, 32'hFFFF_FFFF, 0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 17,           1, 7,          0, 7,             7,  7,  1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 18,           0, 7,          0, 7,             7,  7,  1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 19,           0, 7,          0, 32'hFFFF_FFFF, 0,  0,  0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 100,          0, 7,          1, 32'hFFFF_FFFF, 0,  0,  0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 102,          0, 7,          2, 32'hFFFF_FFFF, 0,  0,  0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 104,          0, 7,          3, 32'hFFFF_FFFF, 0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 110,          1, 10,         2, 10,            10, 10, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 111,          1, 9,          1, 9,             10, 19, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 120,          1, 16,         0, 9,             16, 35, 3, 0, 0));
    tbl.push_back(mk(0, 0, 1, 121,          0, 16,         0, 32'hFFFF_FFFF, 0,  0,  0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 32'hFFFF_FFFE, 0, 16,        1, 32'hFFFF_FFFF, 0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 3,            1, 5,          0, 5,             5,  5,  1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4,            0, 5,          0, 5,             5,  5,  1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 5,            1, 0,          0, 0,             5,  5,  2, 0, 1));
    tbl.push_back(mk(1, 0, 1, 10,           0, 0,          1, 32'hFFFF_FFFF, 0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 14,           1, 4,          0, 32'hFFFF_FFFF, 0,  0,  0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 15,           0, 4,          0, 32'hFFFF_FFFF, 0,  0,  0, 0, 1));

    foreach (tbl[i]) begin
      tag = $sformatf("vec%0d", i);
      step(tbl[i].s, tbl[i].e, tbl[i].clr, tbl[i].cc, {tag, ".model"});
      chk({tag, ".valid"}, 64'(lat_valid), 64'(tbl[i].ev));
      chk({tag, ".last"}, 64'(lat_last), 64'(tbl[i].el));
      chk({tag, ".inflight"}, 64'(inflight), 64'(tbl[i].ei));
      chk({tag, ".min"}, 64'(lat_min), 64'(tbl[i].emin));
      chk({tag, ".max"}, 64'(lat_max), 64'(tbl[i].emax));
      chk({tag, ".sum"}, 64'(lat_sum), 64'(tbl[i].esum));
      chk({tag, ".count"}, 64'(msg_count), 64'(tbl[i].ecnt));
      chk({tag, ".ovf"}, 64'(overflow_err), 64'(tbl[i].eovf));
      chk({tag, ".unf"}, 64'(underflow_err), 64'(tbl[i].eunf));
    end

    // Fill past capacity, then simultaneous start/end while full, then drain.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 32'(200 + i), "fill");
    chk("full.inflight", 64'(inflight), 64'd8);
    chk("full.ovf", 64'(overflow_err), 64'd1);
    step(1'b0, 1'b0, 1'b1, 32'd250, "full.clear");
    step(1'b1, 1'b1, 1'b0, 32'd300, "full.both");
    chk("full.both.inflight", 64'(inflight), 64'd8);
    chk("full.both.ovf", 64'(overflow_err), 64'd0);
    chk("full.both.last", 64'(lat_last), 64'd100);
    for (int i = 0; i < 7; i++) drain_exp[i] = 32'd199;
    drain_exp[7] = 32'd107;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'(400 + i), "drain");
      chk($sformatf("drain%0d.valid", i), 64'(lat_valid), 64'd1);
      chk($sformatf("drain%0d.last", i), 64'(lat_last), 64'(drain_exp[i]));
    end
    chk("drain.inflight", 64'(inflight), 64'd0);

    // Asynchronous reset with three messages in flight.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'(500 + i), "pre_rst");
    step(1'b0, 1'b1, 1'b0, 32'd510, "pre_rst.end");
    chk("pre_rst.inflight", 64'(inflight), 64'd2);
    step(1'b1, 1'b0, 1'b0, 32'd511, "pre_rst.push");
    chk("pre_rst.inflight3", 64'(inflight), 64'd3);
    start_evt = 1'b0; end_evt = 1'b0; clear = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, 32'd600, "post_rst.end");
    chk("post_rst.unf", 64'(underflow_err), 64'd1);
    step(1'b0, 1'b0, 1'b1, 32'd601, "post_rst.clear");

    // Randomized traffic, starting near the counter wrap point.
    cc_r = 32'hFFFF_F000;
    for (int i = 0; i < 3000; i++) begin
      s_r = ($urandom_range(0, 99) < 50);
      e_r = ($urandom_range(0, 99) < 45);
      c_r = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 19) == 0) cc_r = cc_r + $urandom;
      else cc_r = cc_r + 32'd1;
      step(s_r, e_r, c_r, cc_r, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/latency_monitor.md
# latency_monitor

Parametrised latency measurement block for the trading datapath. Stamps ingress events with the free-running cycle counter, queues up to DEPTH in-flight timestamps in order, and on each decision event computes the ingress-to-decision latency. It keeps running statistics: last, min, max, sum and count. It sits alongside the pipeline register chain and replaces the fixed single-message t_ingress/t_decision capture with overlapped-message measurement.

## Interface
- TS_W, 32, width of cycle counter and latency values
- DEPTH, 8, in-flight timestamp FIFO depth; power of two, ≥2
- CNT_W, 32, width of message counter
- SUM_W, 48, width of latency accumulator; SUM_W ≥ TS_W

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cycle_cnt  in  TS_W  free-running cycle counter (wraps)
- start_evt  in  1  ingress event (one message entered)
- end_evt  in  1  decision event (oldest in-flight message completed)
- clear  in  1  synchronous clear of statistics and sticky flags
- lat_valid  out  1  one-cycle pulse: new latency sample on lat_last
- lat_last  out  TS_W  most recent latency, cycles
- lat_min  out  TS_W  minimum latency since reset/clear
- lat_max  out  TS_W  maximum latency since reset/clear
- lat_sum  out  SUM_W  saturating sum of latencies
- msg_count  out  CNT_W  saturating number of samples
- inflight  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow_err  out  1  sticky: start_evt dropped because FIFO full
- underflow_err  out  1  sticky: end_evt with nothing in flight

## Operation
- FIFO: circular buffer with read/write pointers of $clog2(DEPTH) bits, wrapping at DEPTH. Occupancy counter ranges 0..DEPTH.
- start_evt alone, not full: push cycle_cnt and increment inflight.
- start_evt alone, full: no push, inflight unchanged, set overflow_err.
- end_evt alone, not empty: pop head. Latency = cycle_cnt − head, modulo 2^TS_W (wrap-safe unsigned subtraction). Decrement inflight.
- end_evt alone, empty: no sample, set underflow_err.
- start_evt and end_evt, not empty: pop head and push cycle_cnt. inflight unchanged; this holds when full too, with no overflow.
- start_evt and end_evt, empty: bypass. Sample latency 0, nothing pushed, inflight stays 0, no error.
- Each sample updates the following on the same edge:
  - lat_last = latency
  - lat_min = min(lat_min, latency)
  - lat_max = max(lat_max, latency)
  - lat_sum += latency, saturating at all-ones
  - msg_count += 1, saturating at all-ones
- clear effects:
  - lat_min ← all-ones; lat_max, lat_sum, msg_count ← 0; sticky flags ← 0.
  - FIFO contents and inflight are untouched.
  - A sample in the same cycle as clear still drives lat_valid/lat_last but is not accumulated.
  - An error condition in the same cycle as clear leaves its flag set; the error wins.
- Reset values:
  - All outputs 0 except lat_min = all-ones.
  - FIFO pointers and occupancy 0.
- Reset asserted mid-operation discards all in-flight timestamps.

## Timing
- Fully registered outputs; no combinational path from inputs to outputs.
- Sample latency: end_evt at edge N → lat_valid high, lat_last and stats updated, after edge N+1. lat_valid lasts exactly one cycle per sample.
- inflight reflects events one cycle after they are presented.
- Back-to-back end_evt on consecutive cycles produce consecutive lat_valid pulses, with no bubble.
- Timestamp taken is the cycle_cnt value present in the same cycle as start_evt. Latency is the difference of cycle_cnt at end and start, so start and end one cycle apart gives 1.

## Test plan
- Single message: start_evt at cycle_cnt=10, end_evt at 17 → lat_valid one cycle later, lat_last=7, min=max=7, sum=7, count=1, inflight back to 0.
- Overlapped: starts at 100, 102, 104; ends at 110, 111, 120 → samples 10, 9, 16 in order; min=9, max=16, sum=35, count=3.
- Wrap: start at cycle_cnt=32'hFFFF_FFFE, end at 32'h0000_0003 → lat_last=5.
- Full/overflow (DEPTH=8): 9 starts with no end → inflight=8, overflow_err=1. Then start and end together while full → inflight stays 8 with no further error. Draining 8 ends returns the 8 oldest stamps in order.
- Empty cases: end_evt alone with inflight=0 → underflow_err=1, no lat_valid. start_evt and end_evt together with inflight=0 → lat_valid, lat_last=0, no error.
- clear coincident with sample: latency 4 pending with clear=1 → lat_last=4, lat_valid=1, count=0, min=all-ones, max=0. Async reset mid-flight with inflight=3 → all outputs at reset values immediately, inflight=0.
